fmul_arbiter: RTL and testbench

- Shares one pipelined fmul (x1, x2 -> y, single clk) among NREQ requesters.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning operands into the fmul and tracks in-flight operations with a tag pipeline.
- Returns each product to its originator with a one-cycle response strobe. Sits between the FPU's clients and the fmul instance.

---
 rtl/fmul_arbiter.sv | 137 +++++++++++++
 tb/tb_fmul_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one pipelined fmul among NREQ requesters.
// Optional per-requester issue counters are enabled with `define FMUL_ARB_STATS_EN.
module fmul_arbiter #(
  parameter int NREQ     = 4,
  parameter int FMUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          fmul_x1,
  output logic [31:0]          fmul_x2,
  input  logic [31:0]          fmul_y,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_y,
  output logic                 busy
`ifdef FMUL_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [NREQ*16-1:0]   stat_cnt
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  logic [IDW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]               gnt_id;
  logic                         gnt_any;
  logic [NREQ-1:0]              gnt_oh;
  logic                         hs;

  logic [31:0]                  x1_q, x1_d, x2_q, x2_d;
  // Stage 0 loads at the handshake edge, so the tag reaches stage FMUL_LAT
  // exactly when fmul_y holds the matching product.
  logic [FMUL_LAT:0]            tag_vld_q, tag_vld_d;
  logic [FMUL_LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic [NREQ-1:0]              resp_vld_q, resp_vld_d;
  logic [31:0]                  resp_y_q, resp_y_d;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % NREQ_U;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_any && rstn) gnt_oh[gnt_id] = 1'b1;
  end

  assign hs        = |gnt_oh;
  assign req_ready = gnt_oh;

  always_comb begin
    int unsigned sel;
    sel        = 32'(gnt_id);
    rr_ptr_d   = rr_ptr_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    if (hs) begin
      rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      x1_d     = req_x1[sel*32 +: 32];
      x2_d     = req_x2[sel*32 +: 32];
    end

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = hs;
    tag_id_d[0]  = gnt_id;
    for (int unsigned s = 1; s <= FMUL_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    resp_vld_d = '0;
    if (tag_vld_q[FMUL_LAT]) resp_vld_d[tag_id_q[FMUL_LAT]] = 1'b1;
    resp_y_d   = fmul_y;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      resp_vld_q <= '0;
      resp_y_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      resp_vld_q <= resp_vld_d;
      resp_y_q   <= resp_y_d;
    end
  end

  assign fmul_x1    = x1_q;
  assign fmul_x2    = x2_q;
  assign resp_valid = resp_vld_q;
  assign resp_y     = resp_y_q;
  assign busy       = (|tag_vld_q) | (|resp_vld_q);

`ifdef FMUL_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; counters saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (hs && (cnt_q[gnt_id] != '1)) begin
      cnt_d[gnt_id] = cnt_q[gnt_id] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: directed scenarios plus random traffic
// against a queue-based response model and a stand-in pipelined fmul.
module tb_fmul_arbiter;

  localparam int NREQ     = 4;
  localparam int FMUL_LAT = 2;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_x1, req_x2;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         fmul_x1, fmul_x2, fmul_y;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_y;
  logic                busy;
`ifdef FMUL_ARB_STATS_EN
  logic                stat_clr;
  logic [NREQ*16-1:0]  stat_cnt;
`endif

  logic [31:0] ox1 [NREQ];
  logic [31:0] ox2 [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_x1[32*i +: 32] = ox1[i];
    assign req_x2[32*i +: 32] = ox2[i];
  end

  fmul_arbiter #(.NREQ(NREQ), .FMUL_LAT(FMUL_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_ready  (req_ready),
    .fmul_x1    (fmul_x1),
    .fmul_x2    (fmul_x2),
    .fmul_y     (fmul_y),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .busy       (busy)
`ifdef FMUL_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_cnt   (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: exact products for the known vectors, a fixed mix otherwise.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40400000_40400000: return 32'h41100000;
      64'h437F0000_C37F0000: return 32'hC77E0100;
      64'h4048F5C3_40000000: return 32'h40C8F5C3;
      64'h40200000_40000000: return 32'h40A00000;
      64'h42C80000_00000000: return 32'h00000000;
      default:               return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
    endcase
  endfunction

  logic [31:0] fpipe [FMUL_LAT];
  always @(posedge clk) begin
    fpipe[0] <= fmodel(fmul_x1, fmul_x2);
    for (int i = 1; i < FMUL_LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fmul_y = fpipe[FMUL_LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } rsp_t;

  rsp_t q[$];
  int   mptr;
  int   cyc;
  int   gcnt [NREQ];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check the grant mid-cycle, then the registered outputs after the edge.
  task automatic step();
    int              g;
    logic [NREQ-1:0] eg;
    rsp_t            r;
    @(negedge clk);
    g  = -1;
    eg = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (mptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(eg));
    if (g >= 0) begin
      r.due = cyc + 1 + FMUL_LAT + 1;
      r.id  = g;
      r.y   = fmodel(ox1[g], ox2[g]);
      q.push_back(r);
      mptr = (g + 1) % NREQ;
      gcnt[g]++;
    end
    @(posedge clk);
    cyc++;
    #1;
    check("busy", 64'(busy), 64'(q.size() != 0));
    if (q.size() != 0 && q[0].due == cyc) begin
      eg = '0;
      eg[q[0].id] = 1'b1;
      check("resp_valid", 64'(resp_valid), 64'(eg));
      check("resp_y", 64'(resp_y), 64'(q[0].y));
      void'(q.pop_front());
    end else begin
      check("resp_valid_idle", 64'(resp_valid), 64'd0);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(3) == 0) begin
        ox1[i] = 32'h437F0000;
        ox2[i] = 32'hC37F0000;
      end else begin
        ox1[i] = $urandom;
        ox2[i] = $urandom;
      end
    end
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '1;
    mptr      = 0;
    cyc       = 0;
    for (int i = 0; i < NREQ; i++) begin
      ox1[i]  = '0;
      ox2[i]  = '0;
      gcnt[i] = 0;
    end
`ifdef FMUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_fmul_x1", 64'(fmul_x1), 64'd0);
    check("rst_fmul_x2", 64'(fmul_x2), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_y", 64'(resp_y), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 3*3 from requester 0
    ox1[0] = 32'h40400000;
    ox2[0] = 32'h40400000;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    check("t1_busy", 64'(busy), 64'd1);
    step();
    step();
    step();
    check("t1_resp_valid", 64'(resp_valid), 64'h1);
    check("t1_resp_y", 64'(resp_y), 64'h41100000);
    step();

    // back-to-back grants to requesters 1 and 2
    ox1[1] = 32'h437F0000; ox2[1] = 32'hC37F0000;
    ox1[2] = 32'h4048F5C3; ox2[2] = 32'h40000000;
    req_valid = 4'b0110;
    step();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    step();
    check("t2_resp_valid_a", 64'(resp_valid), 64'h2);
    check("t2_resp_y_a", 64'(resp_y), 64'hC77E0100);
    step();
    check("t2_resp_valid_b", 64'(resp_valid), 64'h4);
    check("t2_resp_y_b", 64'(resp_y), 64'h40C8F5C3);
    step();

    // pointer now at 3: grant 3, then wrap to 0
    ox1[0] = 32'h40200000; ox2[0] = 32'h40000000;
    ox1[3] = 32'h42C80000; ox2[3] = 32'h00000000;
    req_valid = 4'b1001;
    step();
    check("t4_fmul_x1", 64'(fmul_x1), 64'h42C80000);
    step();
    req_valid = '0;
    step();
    step();
    check("t4_resp_valid_a", 64'(resp_valid), 64'h8);
    check("t4_resp_y_a", 64'(resp_y), 64'h00000000);
    step();
    check("t4_resp_valid_b", 64'(resp_valid), 64'h1);
    check("t4_resp_y_b", 64'(resp_y), 64'h40A00000);
    step();

    // reset with two operations in flight
    req_valid = 4'b0011;
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_resp_y", 64'(resp_y), 64'd0);
    check("mid_rst_fmul_x1", 64'(fmul_x1), 64'd0);
    check("mid_rst_fmul_x2", 64'(fmul_x2), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    mptr = 0;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < FMUL_LAT + 3; i++) step();

    // all requesters valid for 100 cycles
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    req_valid = '1;
    for (int n = 0; n < 100; n++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt%0d", i), 64'(gcnt[i]), 64'd25);
    for (int i = 0; i < FMUL_LAT + 2; i++) step();

    // single requester continuously valid
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    req_valid = 4'b0100;
    for (int n = 0; n < 20; n++) begin
      rand_ops();
      step();
    end
    check("single_cnt", 64'(gcnt[2]), 64'd20);
    req_valid = '0;
    for (int i = 0; i < FMUL_LAT + 2; i++) step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      rand_ops();
      step();
    end
    req_valid = '0;
    for (int i = 0; i < FMUL_LAT + 3; i++) step();
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_queue", 64'(q.size()), 64'd0);

`ifdef FMUL_ARB_STATS_EN
    req_valid = 4'b0001;
    for (int n = 0; n < 70000; n++) step();
    check("stat_sat", 64'(stat_cnt[15:0]), 64'hFFFF);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    req_valid = '0;
    check("stat_clr", 64'(stat_cnt[15:0]), 64'd0);
    for (int i = 0; i < FMUL_LAT + 3; i++) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
